store_buffer: RTL and testbench
===============================

// Module: store_buffer
// PURPOSE
//  Store queue between the CPU memory-access stage and datamem (single-beat AXI write master).
//  Accepts SB/SH/SW requests, aligns data, generates byte strobes, buffers up to DEPTH stores.
//  Issues buffered stores to datamem one at a time via WREN/WRADDR/WRSTRB/WRDATA, paced by LOADING.
//  Flags loads that hit a pending store so the pipeline can stall them.
// PARAMETERS
//  DEPTH  4  queue entries (power of 2, >=2)
//  PTR_W  2  log2(DEPTH)
// PORTS
//  CLK          in   1   clock
//  RSTN         in   1   asynchronous active-low reset
//  ST_VALID     in   1   store request valid
//  ST_READY     out  1   queue can accept (= count != DEPTH)
//  ST_ADDR      in   32  byte address
//  ST_FUNCT3    in   3   000 SB, 001 SH, 010 SW
//  ST_DATA      in   32  rs2 value (low bytes used for SB/SH)
//  ST_ERR       out  1   1-cycle pulse: misaligned or illegal funct3, request dropped
//  LD_ADDR      in   32  address of load in flight
//  LD_HAZARD    out  1   pending entry matches LD_ADDR[31:2] (combinational)
//  EMPTY        out  1   count==0 and FSM in S_IDLE
//  WRADDR       out  32  to datamem: word-aligned address of head entry
//  WREN         out  1   to datamem: 1-cycle issue pulse (registered)
//  WRSTRB       out  4   to datamem: byte strobe of head entry
//  WRDATA       out  32  to datamem: lane-replicated data of head entry
//  LOADING      in   1   from datamem: write channel busy (combinational from its next state)
// BEHAVIOUR
//  Reset (RSTN=0, async): pointers, count=0, FSM S_IDLE, WREN=0, ST_ERR=0, all entries invalid.
//  Enqueue on ST_VALID & ST_READY & legal; no push when full even if pop same cycle.
//  Alignment: WRADDR={addr[31:2],2'b00}.
//   SB: strb=4'b0001<<addr[1:0], data={4{d[7:0]}}.
//   SH: addr[0]=0 required; strb=addr[1]?1100:0011, data={2{d[15:0]}}.
//   SW: addr[1:0]=0 required; strb=1111, data=d.
//   Other funct3 or misaligned -> ST_ERR=1 next cycle, nothing enqueued.
//  FSM (registered):
//   S_IDLE : count!=0 & LOADING=0 -> S_ISSUE, WREN<=1.
//   S_ISSUE: WREN high exactly this cycle -> S_WAIT, WREN<=0.
//   S_WAIT : LOADING=0 -> pop head, count-1, -> S_IDLE; else hold.
//  WRADDR/WRSTRB/WRDATA driven from head entry through S_ISSUE and S_WAIT, stable until pop
//   (datamem samples WRDATA/WRSTRB only after AWREADY).
//  Throughput: one store per (3 + datamem busy) cycles; back-to-back stores need 1 S_IDLE cycle.
//  Push and pop same cycle (not full): count unchanged, both pointers advance, mod DEPTH wrap.
//  LD_HAZARD: OR over valid entries of entry_addr[31:2]==LD_ADDR[31:2], includes head in flight.
//  Reset mid-transfer: queue discarded; RSTN shares reset domain with datamem.
// TESTING
//  SB addr 0x1003 data 0xAB -> WRADDR 0x1000, WRSTRB 1000, WRDATA 0xABABABAB, one WREN pulse.
//  SH addr 0x2001 -> ST_ERR pulse, count stays 0, no WREN; SW addr 0x2002 -> same.
//  5 SW with datamem AWREADY=WREADY=0 -> ST_READY=0 after 4th, 5th held; release -> 4 in order, then 5th.
//  SW 0x3000 pending, LD_ADDR 0x3002 -> LD_HAZARD=1; LD_ADDR 0x3004 -> 0; after pop -> 0.
//  Push while popping at count=2 -> count stays 2, pointer wrap after DEPTH+1 stores correct.
//  RSTN low during S_WAIT -> WREN=0, EMPTY=1 immediately, no further issues.

Source files
------------

// File: rtl/store_buffer.sv
// Store queue between the memory-access stage and datamem: aligns SB/SH/SW requests,
// buffers up to DEPTH of them and issues them one at a time as single-beat writes.
`timescale 1ns/1ps

module store_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic        ST_VALID,
    output logic        ST_READY,
    input  logic [31:0] ST_ADDR,
    input  logic [2:0]  ST_FUNCT3,
    input  logic [31:0] ST_DATA,
    output logic        ST_ERR,
    input  logic [31:0] LD_ADDR,
    output logic        LD_HAZARD,
    output logic        EMPTY,
    output logic [31:0] WRADDR,
    output logic        WREN,
    output logic [3:0]  WRSTRB,
    output logic [31:0] WRDATA,
    input  logic        LOADING
);

    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned WADR_W = 30;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_e;

    state_e              state_q;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [WADR_W-1:0]   e_addr_q [DEPTH];
    logic [3:0]          e_strb_q [DEPTH];
    logic [31:0]         e_data_q [DEPTH];
    logic [DEPTH-1:0]    e_valid_q;

    logic                legal_c;
    logic [3:0]          strb_c;
    logic [31:0]         data_c;
    logic                push_c;
    logic                pop_c;
    logic                hazard_c;

    logic                err_q;
    logic                wren_q;
    logic [31:0]         wraddr_q;
    logic [3:0]          wrstrb_q;
    logic [31:0]         wrdata_q;

    // Decode funct3, check alignment, build lane strobe and replicated data
    always_comb begin
        legal_c = 1'b0;
        strb_c  = 4'b0000;
        data_c  = ST_DATA;
        case (ST_FUNCT3)
            3'b000: begin
                legal_c = 1'b1;
                strb_c  = 4'b0001 << ST_ADDR[1:0];
                data_c  = {4{ST_DATA[7:0]}};
            end
            3'b001: begin
                legal_c = ~ST_ADDR[0];
                strb_c  = ST_ADDR[1] ? 4'b1100 : 4'b0011;
                data_c  = {2{ST_DATA[15:0]}};
            end
            3'b010: begin
                legal_c = (ST_ADDR[1:0] == 2'b00);
                strb_c  = 4'b1111;
                data_c  = ST_DATA;
            end
            default: begin
                legal_c = 1'b0;
            end
        endcase
    end

    assign ST_READY = (count_q != CNT_W'(DEPTH));
    assign push_c   = ST_VALID & ST_READY & legal_c;
    assign pop_c    = (state_q == S_WAIT) & ~LOADING;

    always_comb begin
        count_d  = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
        wr_ptr_d = push_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop_c  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            err_q    <= 1'b0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            err_q    <= ST_VALID & ~legal_c;
        end
    end

    // Entry storage; push and pop never target the same slot (full blocks push, empty blocks pop)
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            e_valid_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                e_addr_q[i] <= '0;
                e_strb_q[i] <= '0;
                e_data_q[i] <= '0;
            end
        end else begin
            if (push_c) begin
                e_addr_q[wr_ptr_q]  <= ST_ADDR[31:2];
                e_strb_q[wr_ptr_q]  <= strb_c;
                e_data_q[wr_ptr_q]  <= data_c;
                e_valid_q[wr_ptr_q] <= 1'b1;
            end
            if (pop_c) begin
                e_valid_q[rd_ptr_q] <= 1'b0;
            end
        end
    end

    // Word-granular match against every pending entry, including the one in flight
    always_comb begin
        hazard_c = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (e_valid_q[i] &&
                ((({e_addr_q[i], 2'b00} ^ LD_ADDR) & 32'hFFFF_FFFC) == 32'h0000_0000)) begin
                hazard_c = 1'b1;
            end
        end
    end

    // Issue FSM; head payload is captured at issue and held until the pop
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q  <= S_IDLE;
            wren_q   <= 1'b0;
            wraddr_q <= '0;
            wrstrb_q <= '0;
            wrdata_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    wren_q <= 1'b0;
                    if ((count_q != '0) && !LOADING) begin
                        state_q  <= S_ISSUE;
                        wren_q   <= 1'b1;
                        wraddr_q <= {e_addr_q[rd_ptr_q], 2'b00};
                        wrstrb_q <= e_strb_q[rd_ptr_q];
                        wrdata_q <= e_data_q[rd_ptr_q];
                    end
                end
                S_ISSUE: begin
                    state_q <= S_WAIT;
                    wren_q  <= 1'b0;
                end
                S_WAIT: begin
                    wren_q <= 1'b0;
                    if (!LOADING) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    wren_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ST_ERR    = err_q;
    assign LD_HAZARD = hazard_c;
    assign EMPTY     = (count_q == '0) && (state_q == S_IDLE);
    assign WREN      = wren_q;
    assign WRADDR    = wraddr_q;
    assign WRSTRB    = wrstrb_q;
    assign WRDATA    = wrdata_q;

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: directed stores push expected writes, a monitor
// compares each WREN beat; a small datamem model drives LOADING.
`timescale 1ns/1ps

module tb_store_buffer;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] data;
    } exp_t;

    logic        CLK;
    logic        RSTN;
    logic        ST_VALID;
    logic        ST_READY;
    logic [31:0] ST_ADDR;
    logic [2:0]  ST_FUNCT3;
    logic [31:0] ST_DATA;
    logic        ST_ERR;
    logic [31:0] LD_ADDR;
    logic        LD_HAZARD;
    logic        EMPTY;
    logic [31:0] WRADDR;
    logic        WREN;
    logic [3:0]  WRSTRB;
    logic [31:0] WRDATA;
    logic        LOADING;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   err_seen = 0;
    int   err_exp  = 0;
    int   wren_seen = 0;
    int   accepted = 0;
    int   discarded = 0;
    exp_t exp_q[$];

    int   lat  = 2;
    bit   hold = 1'b0;
    int   busy_cnt;

    store_buffer #(.DEPTH(4), .PTR_W(2)) dut (
        .CLK       (CLK),
        .RSTN      (RSTN),
        .ST_VALID  (ST_VALID),
        .ST_READY  (ST_READY),
        .ST_ADDR   (ST_ADDR),
        .ST_FUNCT3 (ST_FUNCT3),
        .ST_DATA   (ST_DATA),
        .ST_ERR    (ST_ERR),
        .LD_ADDR   (LD_ADDR),
        .LD_HAZARD (LD_HAZARD),
        .EMPTY     (EMPTY),
        .WRADDR    (WRADDR),
        .WREN      (WREN),
        .WRSTRB    (WRSTRB),
        .WRDATA    (WRDATA),
        .LOADING   (LOADING)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // datamem stand-in: busy for 'lat' cycles after each WREN, frozen while 'hold'
    always @(posedge CLK or negedge RSTN) begin
        if (!RSTN)                         busy_cnt <= 0;
        else if (WREN)                     busy_cnt <= lat;
        else if (busy_cnt != 0 && !hold)   busy_cnt <= busy_cnt - 1;
    end
    assign LOADING = WREN | (busy_cnt != 0);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every WREN beat must match the oldest expected write
    always @(negedge CLK) begin
        if (RSTN) begin
            if (ST_ERR) err_seen++;
            if (WREN) begin
                wren_seen++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_wren: got WRADDR 0x%08h expected no write at %0t", WRADDR, $time);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("wraddr", WRADDR, e.addr);
                    check("wrstrb", 32'(WRSTRB), 32'(e.strb));
                    check("wrdata", WRDATA, e.data);
                end
            end
        end
    end

    task automatic do_store(input logic [31:0] a, input logic [2:0] f, input logic [31:0] d,
                            input bit ok, input logic [31:0] ea, input logic [3:0] es,
                            input logic [31:0] ed);
        int guard;
        exp_t e;
        @(negedge CLK);
        ST_VALID  = 1'b1;
        ST_ADDR   = a;
        ST_FUNCT3 = f;
        ST_DATA   = d;
        guard = 0;
        while (ok && !ST_READY && guard < 500) begin
            @(negedge CLK);
            guard++;
        end
        if (guard >= 500) begin
            n_checks++;
            n_fail++;
            $display("FAIL st_ready_timeout: got ST_READY 0 expected 1 within 500 cycles");
        end else if (ok) begin
            e.addr = ea;
            e.strb = es;
            e.data = ed;
            exp_q.push_back(e);
            accepted++;
        end else begin
            err_exp++;
        end
        @(posedge CLK);
        #1 ST_VALID = 1'b0;
    endtask

    task automatic wait_empty(input string name);
        int guard;
        guard = 0;
        @(negedge CLK);
        while (!EMPTY && guard < 300) begin
            @(negedge CLK);
            guard++;
        end
        check(name, 32'(EMPTY), 32'd1);
    endtask

    initial begin
        int base;
        RSTN = 1'b0;
        ST_VALID = 1'b0;
        ST_ADDR = '0;
        ST_FUNCT3 = '0;
        ST_DATA = '0;
        LD_ADDR = 32'h0000_0000;

        #12;
        check("rst_wren", 32'(WREN), 32'd0);
        check("rst_empty", 32'(EMPTY), 32'd1);
        check("rst_ready", 32'(ST_READY), 32'd1);
        check("rst_err", 32'(ST_ERR), 32'd0);
        check("rst_hazard", 32'(LD_HAZARD), 32'd0);
        @(negedge CLK);
        RSTN = 1'b1;

        // SB to the top byte lane
        do_store(32'h0000_1003, 3'b000, 32'h0000_00AB, 1'b1, 32'h0000_1000, 4'b1000, 32'hABAB_ABAB);
        wait_empty("drain_sb");

        // Misaligned and illegal requests are dropped with an error pulse
        do_store(32'h0000_2001, 3'b001, 32'h1234_5678, 1'b0, '0, '0, '0);
        do_store(32'h0000_2002, 3'b010, 32'h1234_5678, 1'b0, '0, '0, '0);
        do_store(32'h0000_2000, 3'b011, 32'h1234_5678, 1'b0, '0, '0, '0);
        repeat (3) @(negedge CLK);
        check("err_empty", 32'(EMPTY), 32'd1);
        check("err_pulses_mid", 32'(err_seen), 32'd3);

        // Lane patterns
        do_store(32'h0000_1000, 3'b000, 32'h1234_5678, 1'b1, 32'h0000_1000, 4'b0001, 32'h7878_7878);
        do_store(32'h0000_1001, 3'b000, 32'h1234_5678, 1'b1, 32'h0000_1000, 4'b0010, 32'h7878_7878);
        do_store(32'h0000_1002, 3'b001, 32'hBEEF_CAFE, 1'b1, 32'h0000_1000, 4'b1100, 32'hCAFE_CAFE);
        do_store(32'h0000_1000, 3'b001, 32'hBEEF_CAFE, 1'b1, 32'h0000_1000, 4'b0011, 32'hCAFE_CAFE);
        do_store(32'h0000_4000, 3'b010, 32'hDEAD_BEEF, 1'b1, 32'h0000_4000, 4'b1111, 32'hDEAD_BEEF);
        wait_empty("drain_lanes");

        // Full queue with datamem stalled: 5th store held until release
        hold = 1'b1;
        do_store(32'h0000_5000, 3'b010, 32'h5000_0000, 1'b1, 32'h0000_5000, 4'b1111, 32'h5000_0000);
        do_store(32'h0000_5004, 3'b010, 32'h5000_0004, 1'b1, 32'h0000_5004, 4'b1111, 32'h5000_0004);
        do_store(32'h0000_5008, 3'b010, 32'h5000_0008, 1'b1, 32'h0000_5008, 4'b1111, 32'h5000_0008);
        do_store(32'h0000_500C, 3'b010, 32'h5000_000C, 1'b1, 32'h0000_500C, 4'b1111, 32'h5000_000C);
        check("ready_after_4th", 32'(ST_READY), 32'd0);
        fork
            do_store(32'h0000_5010, 3'b010, 32'h5000_0010, 1'b1, 32'h0000_5010, 4'b1111, 32'h5000_0010);
            begin
                repeat (4) begin
                    @(negedge CLK);
                    #1 check("ready_held", 32'(ST_READY), 32'd0);
                end
                hold = 1'b0;
            end
        join
        wait_empty("drain_full");

        // Load hazard against a pending store
        hold = 1'b1;
        do_store(32'h0000_3000, 3'b010, 32'h3333_3333, 1'b1, 32'h0000_3000, 4'b1111, 32'h3333_3333);
        repeat (3) @(negedge CLK);
        LD_ADDR = 32'h0000_3002;
        #1 check("hazard_hit", 32'(LD_HAZARD), 32'd1);
        LD_ADDR = 32'h0000_3004;
        #1 check("hazard_miss", 32'(LD_HAZARD), 32'd0);
        LD_ADDR = 32'h0000_3002;
        hold = 1'b0;
        wait_empty("drain_hazard");
        #1 check("hazard_after_pop", 32'(LD_HAZARD), 32'd0);

        // Back-to-back stream: push/pop overlap and pointer wrap
        lat = 1;
        for (int i = 0; i < 7; i++) begin
            do_store(32'h0000_7000 + 32'(i * 4), 3'b010, 32'h1111_1111 * 32'(i + 1), 1'b1,
                     32'h0000_7000 + 32'(i * 4), 4'b1111, 32'h1111_1111 * 32'(i + 1));
        end
        do_store(32'h0000_7101, 3'b000, 32'h0000_005A, 1'b1, 32'h0000_7100, 4'b0010, 32'h5A5A_5A5A);
        wait_empty("drain_stream");

        // Reset while a write is outstanding
        lat = 2;
        hold = 1'b1;
        base = wren_seen;
        do_store(32'h0000_6000, 3'b010, 32'h600D_600D, 1'b1, 32'h0000_6000, 4'b1111, 32'h600D_600D);
        do_store(32'h0000_6004, 3'b010, 32'h600D_6004, 1'b1, 32'h0000_6004, 4'b1111, 32'h600D_6004);
        for (int g = 0; g < 50 && wren_seen == base; g++) @(negedge CLK);
        check("issued_before_reset", 32'(wren_seen - base), 32'd1);
        @(negedge CLK);
        LD_ADDR = 32'h0000_6004;
        #2 RSTN = 1'b0;
        #1;
        check("midrst_wren", 32'(WREN), 32'd0);
        check("midrst_empty", 32'(EMPTY), 32'd1);
        check("midrst_ready", 32'(ST_READY), 32'd1);
        check("midrst_hazard", 32'(LD_HAZARD), 32'd0);
        discarded = exp_q.size();
        exp_q.delete();
        hold = 1'b0;
        @(negedge CLK);
        RSTN = 1'b1;
        repeat (20) @(negedge CLK);
        check("post_rst_empty", 32'(EMPTY), 32'd1);

        check("err_pulses", 32'(err_seen), 32'(err_exp));
        check("pending_left", 32'(exp_q.size()), 32'd0);
        check("wren_count", 32'(wren_seen), 32'(accepted - discarded));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
